// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Each bit is held CLKS_PER_BIT cycles; a word is accepted over VALID/READY in IDLE only.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  output logic             TXD,
  output logic             BUSY,
  output logic             DONE
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [TW-1:0]    r_tick;
  logic [BW-1:0]    r_bit;
  logic             r_txd;
  logic             r_done;
  logic             w_wrap;

  assign w_wrap = (r_tick == TICK_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_tick <= w_wrap ? '0 : r_tick + TW'(1);
      case (r_state)
        S_IDLE: if (VALID) begin
          r_state <= S_START;
          r_shreg <= DIN;
          r_txd   <= 1'b0;
          r_tick  <= '0;
        end
        // The shift register always presents the next bit to send at bit 0.
        S_START: if (w_wrap) begin
          r_state <= S_DATA;
          r_txd   <= r_shreg[0];
          r_shreg <= r_shreg >> 1;
          r_bit   <= '0;
        end
        S_DATA: if (w_wrap) begin
          if (r_bit == BIT_LAST) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end else begin
            r_bit   <= r_bit + BW'(1);
            r_txd   <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
          end
        end
        S_STOP: if (w_wrap) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign READY = (r_state == S_IDLE);
  assign BUSY  = (r_state != S_IDLE);
  assign TXD   = r_txd;
  assign DONE  = r_done;

endmodule

// File: doc/serial_tx.md
# serial_tx

Parameterised serial transmitter: it accepts a parallel word through a VALID/READY handshake and shifts it out on a single line as a framed serial stream (start bit, data LSB first, stop bit). It is the sending end of the team's serial capture path and drives the line that the latch/shift-based receiver samples. Line timing comes from an internal per-bit clock divider, so a frame needs no extra strobes.

## Interface
Parameters:
- WIDTH, default 8, data bits per frame (≥1).
- CLKS_PER_BIT, default 4, CLK cycles per serial bit (≥1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  parallel word to send; sampled only on acceptance.
- VALID  input  1  DIN holds a word to send.
- READY  output  1  transmitter can accept a word; high only in IDLE.
- TXD  output  1  serial line, registered; idles high.
- BUSY  output  1  a frame is in progress (START, DATA or STOP).
- DONE  output  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- Reset values: TXD=1, READY=1, BUSY=0, DONE=0, state IDLE, shift register and counters 0.
- States:
  - IDLE: TXD=1, READY=1. Goes to START when VALID&&READY at a CLK edge.
  - START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: WIDTH bits, each held CLKS_PER_BIT cycles, LSB first, then STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then IDLE.
- Acceptance: DIN is copied into the shift register at the accepting edge. Later changes to DIN are ignored until the next acceptance.
- VALID while not READY is ignored. There is no queue and no error flag.
- Tick counter: counts 0..CLKS_PER_BIT-1 and advances the bit position on wrap. Width is max(1, clog2(CLKS_PER_BIT)).
- Bit counter: counts 0..WIDTH-1 in DATA. Width is max(1, clog2(WIDTH)).
- Shift register: shifts right once per data bit. TXD takes bit 0.
- BUSY = (state != IDLE). READY = (state == IDLE).
- DONE is set on the edge that leaves STOP and cleared on the next edge.
- Reset mid-frame: on RST assertion TXD goes to 1 immediately (asynchronously) and the frame is aborted. DONE is not pulsed. After RST deasserts, the block restarts in IDLE.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle. The tick counter stays at 0.

## Timing
- Accepting edge k: from edge k, TXD=0, READY=0, BUSY=1.
- Data bit i is driven from edge k+(1+i)·CLKS_PER_BIT.
- Stop bit is driven from edge k+(WIDTH+1)·CLKS_PER_BIT.
- At edge k+(WIDTH+2)·CLKS_PER_BIT: state is IDLE, DONE=1, READY=1, BUSY=0, TXD stays 1.
- The earliest next acceptance is edge k+(WIDTH+2)·CLKS_PER_BIT+1.
- Minimum frame period is therefore (WIDTH+2)·CLKS_PER_BIT+1 cycles. With VALID held high, frames repeat at that period with one idle-high cycle between them.
- No combinational path from any input to any output. READY is derived from the state register only.

## Test plan
- Reset idle: assert RST for 3 cycles, then release and hold VALID=0 for 20 cycles -> TXD=1, READY=1, BUSY=0, DONE=0 throughout.
- Single frame (WIDTH=8, CLKS_PER_BIT=4): DIN=0xA5 with VALID for one cycle -> TXD levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. DONE pulses once, 40 cycles after acceptance, and READY rises in the same cycle.
- Back-to-back: send 0x00 then 0xFF with VALID held high -> second start bit begins 41 cycles after the first acceptance. TXD is high for exactly 1 cycle between the frames. Received bytes are 0x00 and 0xFF.
- Ignored inputs: during a 0x3C frame, toggle DIN and pulse VALID mid-frame -> serial data is still 0x3C, exactly one DONE pulse, no extra frame.
- Reset mid-frame: assert RST at data bit 3 of a 0x81 frame -> TXD=1 in the same cycle, no DONE. After release, a new 0x81 frame transmits correctly.
- Edge parameters: WIDTH=1 and CLKS_PER_BIT=1, DIN=1 -> TXD sequence 0,1,1, DONE 3 cycles after acceptance, frame period 4 cycles.
